// File: rtl/saturn_instr_decoder.sv
// rtl/saturn_instr_decoder.sv - Saturn group-0 instruction decoder/sequencer (trace: SATURN_DEC_TRACE_EN)
module saturn_instr_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_cycles,
  input  logic        i_en_dbg,
  input  logic        i_en_dec,
  input  logic        i_en_exec,
  input  logic [3:0]  i_nibble,
  output logic [19:0] o_pc,
  output logic        o_dec_error
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GRP0 = 1'b1
  } dec_state_e;

  dec_state_e  state_q, state_d;

  logic [19:0] pc_q, pc_d;
  logic        carry_q, carry_d;
  logic        xm_q, xm_d;
  logic        dec_mode_q, dec_mode_d;
  logic [3:0]  p_q, p_d;
  logic [11:0] st_q, st_d;
  logic [19:0] stk_q [8];
  logic [19:0] stk_d [8];
  logic [2:0]  sp_q, sp_d;
  logic        stk_empty_q, stk_empty_d;
  logic [3:0]  op_q, op_d;
  logic        pending_q, pending_d;
  logic        err_pend_q, err_pend_d;
  logic        dec_error_q, dec_error_d;

  // Decode strobes derived from the FSM state
  logic        dec_go;
  logic        exec_go;
  logic        op_latch;
  logic        idle_bad;
  logic        do_ret;

  function automatic logic op_supported(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'hC, 4'hD: op_supported = 1'b1;
      default:                                              op_supported = 1'b0;
    endcase
  endfunction

  // Decode state register; reset discards any partial instruction
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next decode state: a leading 0 opens group 0, the second nibble closes it
  always_comb begin
    state_d = state_q;
    if (dec_go) begin
      case (state_q)
        ST_IDLE: state_d = (i_nibble == 4'h0) ? ST_GRP0 : ST_IDLE;
        ST_GRP0: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Per-state decode actions; everything is frozen once the error flag is set
  always_comb begin
    dec_go   = i_en_dec  & ~dec_error_q;
    exec_go  = i_en_exec & ~dec_error_q;
    op_latch = dec_go & (state_q == ST_GRP0);
    idle_bad = dec_go & (state_q == ST_IDLE) & (i_nibble != 4'h0);
  end

  // Datapath: exec commits the previous instruction, dec latches the new nibble,
  // and a return overrides the PC increment when both land on the same edge
  always_comb begin
    pc_d        = pc_q;
    carry_d     = carry_q;
    xm_d        = xm_q;
    dec_mode_d  = dec_mode_q;
    p_d         = p_q;
    st_d        = st_q;
    stk_d       = stk_q;
    sp_d        = sp_q;
    stk_empty_d = stk_empty_q;
    op_d        = op_q;
    pending_d   = pending_q;
    err_pend_d  = err_pend_q;
    dec_error_d = dec_error_q;
    do_ret      = 1'b0;

    if (exec_go) begin
      if (err_pend_q) begin
        dec_error_d = 1'b1;
      end else if (pending_q) begin
        pending_d = 1'b0;
        case (op_q)
          4'h0: begin xm_d = 1'b1; do_ret = 1'b1; end
          4'h1: do_ret = 1'b1;
          4'h2: begin carry_d = 1'b1; do_ret = 1'b1; end
          4'h3: begin carry_d = 1'b0; do_ret = 1'b1; end
          4'h4: dec_mode_d = 1'b0;
          4'h5: dec_mode_d = 1'b1;
          4'h8: st_d = 12'h000;
          4'hC: begin p_d = p_q + 4'h1; carry_d = (p_q == 4'hF); end
          4'hD: begin p_d = p_q - 4'h1; carry_d = (p_q == 4'h0); end
          default: ;
        endcase
      end
    end

    if (dec_go) begin
      pc_d = pc_q + 20'h00001;
      if (idle_bad) err_pend_d = 1'b1;
      if (op_latch) begin
        op_d = i_nibble;
        if (op_supported(i_nibble)) pending_d  = 1'b1;
        else                        err_pend_d = 1'b1;
      end
    end

    if (do_ret) begin
      if (stk_empty_q) begin
        pc_d = 20'h00000;
      end else begin
        pc_d = stk_q[sp_q];
        if (sp_q == 3'd0) stk_empty_d = 1'b1;
        else              sp_d = sp_q - 3'd1;
      end
    end
  end

  // Architectural and sequencing registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q        <= 20'h00000;
      carry_q     <= 1'b0;
      xm_q        <= 1'b0;
      dec_mode_q  <= 1'b0;
      p_q         <= 4'h0;
      st_q        <= 12'h000;
      for (int i = 0; i < 8; i++) stk_q[i] <= 20'h00000;
      sp_q        <= 3'd0;
      stk_empty_q <= 1'b1;
      op_q        <= 4'h0;
      pending_q   <= 1'b0;
      err_pend_q  <= 1'b0;
      dec_error_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      carry_q     <= carry_d;
      xm_q        <= xm_d;
      dec_mode_q  <= dec_mode_d;
      p_q         <= p_d;
      st_q        <= st_d;
      stk_q       <= stk_d;
      sp_q        <= sp_d;
      stk_empty_q <= stk_empty_d;
      op_q        <= op_d;
      pending_q   <= pending_d;
      err_pend_q  <= err_pend_d;
      dec_error_q <= dec_error_d;
    end
  end

  assign o_pc        = pc_q;
  assign o_dec_error = dec_error_q;

`ifdef SATURN_DEC_TRACE_EN
  logic [3:0] trace_op_q, trace_op_d;
  logic       trace_vld_q, trace_vld_d;

  function automatic string op_name(input logic [3:0] op);
    case (op)
      4'h0: op_name = "RTNSXM";
      4'h1: op_name = "RTN";
      4'h2: op_name = "RTNSC";
      4'h3: op_name = "RTNCC";
      4'h4: op_name = "SETHEX";
      4'h5: op_name = "SETDEC";
      4'h8: op_name = "CLRST";
      4'hC: op_name = "P=P+1";
      4'hD: op_name = "P=P-1";
      default: op_name = "?";
    endcase
  endfunction

  // Remember the last committed opcode for the trace line
  always_comb begin
    trace_op_d  = trace_op_q;
    trace_vld_d = trace_vld_q;
    if (exec_go && pending_q && !err_pend_q) begin
      trace_op_d  = op_q;
      trace_vld_d = 1'b1;
    end
  end

  // Trace register and per-bus-cycle print in the debug slot
  always_ff @(posedge clk) begin
    if (!reset) begin
      trace_op_q  <= 4'h0;
      trace_vld_q <= 1'b0;
    end else begin
      trace_op_q  <= trace_op_d;
      trace_vld_q <= trace_vld_d;
      if (i_en_dbg) begin
        if (dec_error_q)
          $display("[%0d] pc=%05h ERROR", i_cycles, pc_q);
        else
          $display("[%0d] pc=%05h %s", i_cycles, pc_q, trace_vld_q ? op_name(trace_op_q) : "-");
      end
    end
  end
`else
  logic unused_trace;
  assign unused_trace = ^{i_cycles, i_en_dbg, st_q};
`endif

endmodule

// File: tb/tb_saturn_instr_decoder.sv
// tb/tb_saturn_instr_decoder.sv - directed self-checking bench for saturn_instr_decoder
module tb_saturn_instr_decoder;

  logic        clk;
  logic        reset;
  logic [31:0] i_cycles;
  logic        i_en_dbg;
  logic        i_en_dec;
  logic        i_en_exec;
  logic [3:0]  i_nibble;
  logic [19:0] o_pc;
  logic        o_dec_error;

  int n_cmp;
  int n_bad;
  logic [19:0] pc_mid;

  saturn_instr_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .i_cycles   (i_cycles),
    .i_en_dbg   (i_en_dbg),
    .i_en_dec   (i_en_dec),
    .i_en_exec  (i_en_exec),
    .i_nibble   (i_nibble),
    .o_pc       (o_pc),
    .o_dec_error(o_dec_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) i_cycles <= i_cycles + 32'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle: dbg, recv, dec, exec; pc_mid captures PC just after dec
  task automatic bus_cycle(input logic [3:0] n);
    i_en_dbg = 1'b1; tick(); i_en_dbg = 1'b0;
    tick();
    i_nibble = n; i_en_dec = 1'b1; tick(); i_en_dec = 1'b0;
    pc_mid = o_pc;
    i_en_exec = 1'b1; tick(); i_en_exec = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; tick(); tick(); tick();
    reset = 1'b1; tick();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    i_cycles = 32'd0;
    reset = 1'b0; i_en_dbg = 1'b0; i_en_dec = 1'b0; i_en_exec = 1'b0; i_nibble = 4'h0;

    // Reset state, held and released
    tick(); tick(); tick();
    chk("rst_hold_pc", 32'(o_pc), 32'h0);
    chk("rst_hold_err", 32'(o_dec_error), 32'h0);
    reset = 1'b1; tick();
    chk("rst_pc", 32'(o_pc), 32'h0);
    chk("rst_err", 32'(o_dec_error), 32'h0);
    chk("rst_xm", 32'(dut.xm_q), 32'h0);

    // exec with nothing pending is a no-op
    i_en_exec = 1'b1; tick(); i_en_exec = 1'b0;
    chk("idle_exec_pc", 32'(o_pc), 32'h0);

    // RTNSXM
    bus_cycle(4'h0); chk("rtnsxm_pc0", 32'(o_pc), 32'h1);
    bus_cycle(4'h0); chk("rtnsxm_mid", 32'(pc_mid), 32'h2);
    chk("rtnsxm_pc1", 32'(o_pc), 32'h0);
    chk("rtnsxm_xm", 32'(dut.xm_q), 32'h1);

    // RTN, RTNSC, RTNCC, SETHEX stream
    bus_cycle(4'h0); chk("rtn_pc0", 32'(o_pc), 32'h1);
    bus_cycle(4'h1); chk("rtn_pc1", 32'(o_pc), 32'h0);
    bus_cycle(4'h0); bus_cycle(4'h2);
    chk("rtnsc_pc", 32'(o_pc), 32'h0);
    chk("rtnsc_c", 32'(dut.carry_q), 32'h1);
    bus_cycle(4'h0); bus_cycle(4'h3);
    chk("rtncc_pc", 32'(o_pc), 32'h0);
    chk("rtncc_c", 32'(dut.carry_q), 32'h0);
    bus_cycle(4'h0); bus_cycle(4'h4);
    chk("sethex_pc", 32'(o_pc), 32'h2);
    chk("sethex_dm", 32'(dut.dec_mode_q), 32'h0);

    // Unsupported leading nibble -> error, PC frozen
    bus_cycle(4'h4);
    chk("err4_flag", 32'(o_dec_error), 32'h1);
    chk("err4_pc", 32'(o_pc), 32'h3);
    bus_cycle(4'h0); bus_cycle(4'h1);
    chk("frozen_pc", 32'(o_pc), 32'h3);
    chk("frozen_err", 32'(o_dec_error), 32'h1);

    // Unsupported group-0 opcode 06
    do_reset();
    bus_cycle(4'h0); chk("err06_first", 32'(o_dec_error), 32'h0);
    bus_cycle(4'h6); chk("err06_flag", 32'(o_dec_error), 32'h1);
    do_reset();
    chk("err06_rst_err", 32'(o_dec_error), 32'h0);
    chk("err06_rst_pc", 32'(o_pc), 32'h0);

    // P=P-1 then P=P+1 wrap and carry
    bus_cycle(4'h0); bus_cycle(4'hD);
    chk("pdec_p", 32'(dut.p_q), 32'hF);
    chk("pdec_c", 32'(dut.carry_q), 32'h1);
    chk("pdec_pc", 32'(o_pc), 32'h2);
    bus_cycle(4'h0); bus_cycle(4'hC);
    chk("pinc_p", 32'(dut.p_q), 32'h0);
    chk("pinc_c", 32'(dut.carry_q), 32'h1);
    chk("pinc_pc", 32'(o_pc), 32'h4);

    // SETDEC / SETHEX / CLRST
    bus_cycle(4'h0); bus_cycle(4'h5);
    chk("setdec_dm", 32'(dut.dec_mode_q), 32'h1);
    chk("setdec_pc", 32'(o_pc), 32'h6);
    bus_cycle(4'h0); bus_cycle(4'h4);
    chk("sethex2_dm", 32'(dut.dec_mode_q), 32'h0);
    bus_cycle(4'h0); bus_cycle(4'h8);
    chk("clrst_pc", 32'(o_pc), 32'hA);
    chk("clrst_err", 32'(o_dec_error), 32'h0);

    // Simultaneous dec+exec: return target overrides the increment
    do_reset();
    i_nibble = 4'h0; i_en_dec = 1'b1; tick();
    i_nibble = 4'h1; tick();
    chk("sim_pre_pc", 32'(o_pc), 32'h2);
    i_nibble = 4'h0; i_en_exec = 1'b1; tick();
    i_en_dec = 1'b0; i_en_exec = 1'b0;
    chk("sim_ret_pc", 32'(o_pc), 32'h0);
    i_en_exec = 1'b1; tick(); i_en_exec = 1'b0;
    chk("sim_noop_pc", 32'(o_pc), 32'h0);
    bus_cycle(4'h3);
    chk("sim_rtncc_mid", 32'(pc_mid), 32'h1);
    chk("sim_rtncc_pc", 32'(o_pc), 32'h0);

    // Reset mid-instruction drops the pending group-0 prefix
    bus_cycle(4'h0);
    do_reset();
    bus_cycle(4'h1);
    chk("midrst_err", 32'(o_dec_error), 32'h1);
    chk("midrst_pc", 32'(o_pc), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
